// File: rtl/ascii_to_ps2_tx_if.sv
// Character handshake between the string injector and the PS/2 sender.
// The master offers a character; the slave signals when it can take one.
interface ascii_to_ps2_tx_if;
    logic       in_valid;
    logic [7:0] in_ascii;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_ascii,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_ascii,
        output in_ready
    );
endinterface

// File: rtl/ascii_to_ps2_tx.sv
// ASCII to PS/2 set-2 sender: make, F0, make framed onto a generated clock.
// Outputs are registered from next-state values so they align with state.
module ascii_to_ps2_tx #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 8
) (
    input  logic                clk,
    input  logic                rst,
    ascii_to_ps2_tx_if.slave    bus,
    output logic                ps2_clk,
    output logic                ps2_data,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int PW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(GAP) + 1;
    localparam logic [PW-1:0] PH_MAX  = PW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_ph;
    logic          r_half;
    logic [3:0]    r_bit;
    logic [1:0]    r_idx;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_code;

    state_t        w_state_n;
    logic [PW-1:0] w_ph_n;
    logic          w_half_n;
    logic [3:0]    w_bit_n;
    logic [1:0]    w_idx_n;
    logic [GW-1:0] w_gap_n;
    logic [7:0]    w_code_n;

    logic          w_mapped;
    logic [7:0]    w_map_code;
    logic [7:0]    w_byte_n;
    logic [10:0]   w_frame_n;
    logic          w_ps2_clk_n;
    logic          w_ps2_data_n;
    logic          w_busy_n;
    logic          w_done_n;
    logic          w_err_n;

    assign bus.in_ready = (r_state == S_IDLE);

    // Lowercase letters, digits, space and CR to set-2 make codes.
    always_comb begin
        w_mapped   = 1'b1;
        w_map_code = 8'h00;
        case (bus.in_ascii)
            8'h61: w_map_code = 8'h1C;
            8'h62: w_map_code = 8'h32;
            8'h63: w_map_code = 8'h21;
            8'h64: w_map_code = 8'h23;
            8'h65: w_map_code = 8'h24;
            8'h66: w_map_code = 8'h2B;
            8'h67: w_map_code = 8'h34;
            8'h68: w_map_code = 8'h33;
            8'h69: w_map_code = 8'h43;
            8'h6A: w_map_code = 8'h3B;
            8'h6B: w_map_code = 8'h42;
            8'h6C: w_map_code = 8'h4B;
            8'h6D: w_map_code = 8'h3A;
            8'h6E: w_map_code = 8'h31;
            8'h6F: w_map_code = 8'h44;
            8'h70: w_map_code = 8'h4D;
            8'h71: w_map_code = 8'h15;
            8'h72: w_map_code = 8'h2D;
            8'h73: w_map_code = 8'h1B;
            8'h74: w_map_code = 8'h2C;
            8'h75: w_map_code = 8'h3C;
            8'h76: w_map_code = 8'h2A;
            8'h77: w_map_code = 8'h1D;
            8'h78: w_map_code = 8'h22;
            8'h79: w_map_code = 8'h35;
            8'h7A: w_map_code = 8'h1A;
            8'h30: w_map_code = 8'h45;
            8'h31: w_map_code = 8'h16;
            8'h32: w_map_code = 8'h1E;
            8'h33: w_map_code = 8'h26;
            8'h34: w_map_code = 8'h25;
            8'h35: w_map_code = 8'h2E;
            8'h36: w_map_code = 8'h36;
            8'h37: w_map_code = 8'h3D;
            8'h38: w_map_code = 8'h3E;
            8'h39: w_map_code = 8'h46;
            8'h20: w_map_code = 8'h29;
            8'h0D: w_map_code = 8'h5A;
            default: w_mapped = 1'b0;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ph     <= '0;
            r_half   <= 1'b0;
            r_bit    <= '0;
            r_idx    <= '0;
            r_gap    <= '0;
            r_code   <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_ph     <= w_ph_n;
            r_half   <= w_half_n;
            r_bit    <= w_bit_n;
            r_idx    <= w_idx_n;
            r_gap    <= w_gap_n;
            r_code   <= w_code_n;
            ps2_clk  <= w_ps2_clk_n;
            ps2_data <= w_ps2_data_n;
            busy     <= w_busy_n;
            done     <= w_done_n;
            err      <= w_err_n;
        end
    end

    // Next state: bit phases in SEND, idle spacing in GAP, three bytes.
    always_comb begin
        w_state_n = r_state;
        w_ph_n    = r_ph;
        w_half_n  = r_half;
        w_bit_n   = r_bit;
        w_idx_n   = r_idx;
        w_gap_n   = r_gap;
        w_code_n  = r_code;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid && w_mapped) begin
                    w_state_n = S_SEND;
                    w_code_n  = w_map_code;
                    w_idx_n   = '0;
                    w_bit_n   = '0;
                    w_half_n  = 1'b0;
                    w_ph_n    = '0;
                end
            end
            S_SEND: begin
                if (r_ph == PH_MAX) begin
                    w_ph_n = '0;
                    if (!r_half) begin
                        w_half_n = 1'b1;
                    end else begin
                        w_half_n = 1'b0;
                        if (r_bit == 4'd10) begin
                            w_bit_n   = '0;
                            w_gap_n   = '0;
                            w_state_n = S_GAP;
                        end else begin
                            w_bit_n = r_bit + 4'd1;
                        end
                    end
                end else begin
                    w_ph_n = r_ph + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_MAX) begin
                    if (r_idx < 2'd2) begin
                        w_idx_n   = r_idx + 2'd1;
                        w_bit_n   = '0;
                        w_half_n  = 1'b0;
                        w_ph_n    = '0;
                        w_state_n = S_SEND;
                    end else begin
                        w_state_n = S_DONE;
                    end
                end else begin
                    w_gap_n = r_gap + 1'b1;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, decoded from next state.
    always_comb begin
        w_byte_n     = (w_idx_n == 2'd1) ? 8'hF0 : w_code_n;
        w_frame_n    = {1'b1, ~^w_byte_n, w_byte_n, 1'b0};
        w_ps2_clk_n  = !((w_state_n == S_SEND) && w_half_n);
        w_ps2_data_n = 1'b1;
        if (w_state_n == S_SEND) begin
            w_ps2_data_n = w_frame_n[w_bit_n];
        end
        w_busy_n = (w_state_n != S_IDLE);
        w_done_n = (w_state_n == S_DONE);
        w_err_n  = (r_state == S_IDLE) && bus.in_valid && !w_mapped;
    end
endmodule

// File: tb/tb_ascii_to_ps2_tx.sv
// Bench for ascii_to_ps2_tx: scoreboard of expected bytes, done and err.
// A monitor decodes frames on ps2_clk falling edges and checks them.
module tb_ascii_to_ps2_tx;
    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    logic busy;
    logic done;
    logic err;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] byte_q[$];
    int         done_q[$];
    int         err_q[$];

    ascii_to_ps2_tx_if bus();

    ascii_to_ps2_tx #(.CLK_DIV(2), .GAP(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame, done and err monitor.
    logic [10:0] sh;
    int          nb = 0;
    logic        pclk = 1'b1;
    logic [7:0]  eb;
    int          ec;
    always @(negedge clk) begin
        if (rst) begin
            nb   = 0;
            pclk = 1'b1;
        end else begin
            if (pclk && !ps2_clk) begin
                sh[nb] = ps2_data;
                nb++;
                if (nb == 11) begin
                    nb = 0;
                    if (byte_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        eb = byte_q.pop_front();
                        chk("start_bit", int'(sh[0]), 0);
                        chk("data_byte", int'(sh[8:1]), int'(eb));
                        chk("parity", int'(sh[9]), int'(~^eb));
                        chk("stop_bit", int'(sh[10]), 1);
                    end
                end
            end
            pclk = ps2_clk;
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    ec = done_q.pop_front();
                    chk("done_cycle", cyc, ec);
                end
            end
            if (err) begin
                if (err_q.size() == 0) begin
                    chk("unexpected_err", 1, 0);
                end else begin
                    ec = err_q.pop_front();
                    chk("err_cycle", cyc, ec);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] code, input int c);
        byte_q.push_back(code);
        byte_q.push_back(8'hF0);
        byte_q.push_back(code);
        done_q.push_back(c + 145);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(bus.in_ready && done_q.size() == 0) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 0, 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] code,
                        input bit mapped, output int c);
        bus.in_valid = 1'b1;
        bus.in_ascii = a;
        wait_ready();
        c = cyc;
        if (mapped) push_exp(code, c);
        else err_q.push_back(c + 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int c2;
        int bad;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_ascii = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_ps2_clk", int'(ps2_clk), 1);
        chk("rst_ps2_data", int'(ps2_data), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 'q' then 'a'
        send(8'h71, 8'h15, 1'b1, c);
        chk("start_bit_t1", int'(ps2_data), 0);
        chk("busy_t1", int'(busy), 1);
        chk("clk_high_t1", int'(ps2_clk), 1);
        wait_idle();
        send(8'h61, 8'h1C, 1'b1, c);
        wait_idle();

        // 's' then CR with in_valid held
        bus.in_valid = 1'b1;
        bus.in_ascii = 8'h73;
        wait_ready();
        c = cyc;
        push_exp(8'h1B, c);
        @(posedge clk); #1;
        bus.in_ascii = 8'h0D;
        wait_ready();
        c2 = cyc;
        chk("b2b_accept", c2, c + 146);
        push_exp(8'h5A, c2);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_idle();

        // unmapped 'A'
        send(8'h41, 8'h00, 1'b0, c);
        chk("unmapped_ready", int'(bus.in_ready), 1);
        chk("unmapped_busy", int'(busy), 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ps2_clk || !ps2_data || busy) bad = 1;
            @(posedge clk); #1;
        end
        chk("unmapped_idle", bad, 0);

        // reset during the F0 frame of 'f'
        send(8'h66, 8'h2B, 1'b1, c);
        while (cyc < c + 59) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        byte_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        chk("midrst_ps2_clk", int'(ps2_clk), 1);
        chk("midrst_ps2_data", int'(ps2_data), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        send(8'h31, 8'h16, 1'b1, c);
        wait_idle();

        // 'z' offered while 'm' is in flight
        send(8'h6D, 8'h3A, 1'b1, c);
        repeat (30) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_ascii = 8'h7A;
        chk("busy_not_ready", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_idle();

        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("bytes_left", byte_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        chk("err_left", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
